// File: rtl/dragon_jump.sv
// rtl/dragon_jump.sv - vertical-motion controller for the dragon sprite
module dragon_jump #(
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned TOP_Y    = 40,
  parameter int unsigned JUMP_V0  = 15,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 15
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       update,
  input  logic       jump_btn,
  output logic [9:0] dragon_y,
  output logic       airborne,
  output logic       rising,
  output logic       landed
);

  localparam logic [10:0] LP_GROUND = 11'(GROUND_Y);
  localparam logic [10:0] LP_TOP    = 11'(TOP_Y);
  localparam logic [5:0]  LP_V0     = 6'(JUMP_V0);
  localparam logic [5:0]  LP_GRAV   = 6'(GRAVITY);
  localparam logic [5:0]  LP_MAXF   = 6'(MAX_FALL);

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_vel;
  logic [5:0]  w_vel_nxt;
  logic [9:0]  r_y;
  logic [9:0]  w_y_nxt;
  logic        w_landed_nxt;
  logic        r_landed;
  logic        r_airborne;
  logic        r_rising;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_pending;
  logic        w_jump_edge;
  logic [10:0] w_rise_y;
  logic [6:0]  w_fall_sum;
  logic [5:0]  w_fall_v;
  logic [10:0] w_fall_y;

  // r_sync3 is the previous synchronized sample, so the edge is a rise seen at the sync output.
  assign w_jump_edge = r_sync2 & ~r_sync3;

  // Upward step may go negative, so it is evaluated one bit wider and compared signed.
  assign w_rise_y   = {1'b0, r_y} - {5'b0, r_vel};
  // Seven-bit sum cannot wrap for 6-bit operands; the clamp caps it at terminal speed.
  assign w_fall_sum = {1'b0, r_vel} + {1'b0, LP_GRAV};
  assign w_fall_v   = (w_fall_sum > {1'b0, LP_MAXF}) ? LP_MAXF : w_fall_sum[5:0];
  assign w_fall_y   = {1'b0, r_y} + {5'b0, w_fall_v};

  // Button synchronizer and edge-detect history.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= jump_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Pending jump: any tick in the air drops it, a tick on the ground consumes it.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (update && (r_state != S_GROUND)) begin
      r_pending <= 1'b0;
    end else if (update && (r_pending || w_jump_edge)) begin
      r_pending <= 1'b0;
    end else if (w_jump_edge) begin
      r_pending <= 1'b1;
    end
  end

  // Trajectory next-state: everything holds unless a tick is present.
  always_comb begin
    w_state_nxt  = r_state;
    w_vel_nxt    = r_vel;
    w_y_nxt      = r_y;
    w_landed_nxt = 1'b0;
    if (update) begin
      case (r_state)
        S_GROUND: begin
          if (r_pending || w_jump_edge) begin
            w_state_nxt = S_RISE;
            w_vel_nxt   = LP_V0;
          end
        end
        S_RISE: begin
          if ($signed(w_rise_y) < $signed(LP_TOP)) begin
            w_y_nxt     = LP_TOP[9:0];
            w_vel_nxt   = 6'd0;
            w_state_nxt = S_FALL;
          end else begin
            w_y_nxt = w_rise_y[9:0];
            if (r_vel <= LP_GRAV) begin
              w_vel_nxt   = 6'd0;
              w_state_nxt = S_FALL;
            end else begin
              w_vel_nxt = r_vel - LP_GRAV;
            end
          end
        end
        S_FALL: begin
          if (w_fall_y >= LP_GROUND) begin
            w_y_nxt      = LP_GROUND[9:0];
            w_vel_nxt    = 6'd0;
            w_state_nxt  = S_GROUND;
            w_landed_nxt = 1'b1;
          end else begin
            w_y_nxt   = w_fall_y[9:0];
            w_vel_nxt = w_fall_v;
          end
        end
        default: begin
          w_state_nxt = S_GROUND;
        end
      endcase
    end
  end

  // State, speed, position and flag registers; flags derive from the next state so they stay registered.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state    <= S_GROUND;
      r_vel      <= 6'd0;
      r_y        <= LP_GROUND[9:0];
      r_landed   <= 1'b0;
      r_airborne <= 1'b0;
      r_rising   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vel      <= w_vel_nxt;
      r_y        <= w_y_nxt;
      r_landed   <= w_landed_nxt;
      r_airborne <= (w_state_nxt != S_GROUND);
      r_rising   <= (w_state_nxt == S_RISE);
    end
  end

  assign dragon_y = r_y;
  assign airborne = r_airborne;
  assign rising   = r_rising;
  assign landed   = r_landed;

endmodule

// File: tb/tb_dragon_jump.sv
// tb/tb_dragon_jump.sv - randomized and directed bench for dragon_jump
module tb_dragon_jump;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic       jump_btn = 1'b0;
  logic [9:0] y_a, y_b;
  logic       air_a, rise_a, land_a, air_b, rise_b, land_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dragon_jump dut (
    .pixel_clk(clk), .rst(rst), .update(update), .jump_btn(jump_btn),
    .dragon_y(y_a), .airborne(air_a), .rising(rise_a), .landed(land_a)
  );

  dragon_jump #(.JUMP_V0(40)) dut_c (
    .pixel_clk(clk), .rst(rst), .update(update), .jump_btn(jump_btn),
    .dragon_y(y_b), .airborne(air_b), .rising(rise_b), .landed(land_b)
  );

  // Reference model: position/speed with ground=400, top=40, gravity=1, terminal=15.
  typedef struct {
    int y;
    int v;
    bit air;
    bit up;
    bit pend;
    bit landed;
    bit h1;
    bit h2;
    bit h3;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t s, bit r, bit u, bit b, int v0);
    mdl_t n;
    bit   e;
    int   vn;
    n = s;
    if (r) begin
      n.y = 400; n.v = 0; n.air = 0; n.up = 0; n.pend = 0; n.landed = 0;
      n.h1 = 0; n.h2 = 0; n.h3 = 0;
      return n;
    end
    e = s.h2 && !s.h3;
    n.h1 = b; n.h2 = s.h1; n.h3 = s.h2;
    n.landed = 0;
    if (u) begin
      if (s.air) begin
        n.pend = 0;
        if (s.up) begin
          if (s.y - s.v < 40) begin
            n.y = 40; n.v = 0; n.up = 0;
          end else begin
            n.y = s.y - s.v;
            if (s.v <= 1) begin n.v = 0; n.up = 0; end
            else n.v = s.v - 1;
          end
        end else begin
          vn = (s.v + 1 > 15) ? 15 : s.v + 1;
          if (s.y + vn >= 400) begin
            n.y = 400; n.v = 0; n.air = 0; n.landed = 1;
          end else begin
            n.y = s.y + vn; n.v = vn;
          end
        end
      end else if (s.pend || e) begin
        n.air = 1; n.up = 1; n.v = v0; n.pend = 0;
      end
    end else if (e) begin
      n.pend = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, rst, update, jump_btn, 15);
    mb = mstep(mb, rst, update, jump_btn, 40);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic press();
    jump_btn = 1'b1;
    idle(2);
    jump_btn = 1'b0;
    idle(4);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while ((air_a || air_b) && k < 100) begin
      tick();
      idle(1);
      k++;
    end
    n_vec++;
    if (air_a || air_b) begin
      n_err++;
      $display("FAIL settle_timeout: airborne a=%0b b=%0b expected 0 0", air_a, air_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_vec++;
    if ({y_a, air_a, rise_a, land_a} !== {10'd400, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got y=%0d air=%0b rise=%0b land=%0b expected 400 0 0 0", y_a, air_a, rise_a, land_a);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (land_a !== 1'b0 || air_a !== 1'b0) begin
        n_err++;
        $display("FAIL idle_tick%0d: got land=%0b air=%0b expected 0 0", i, land_a, air_a);
      end
      idle(1);
    end
    n_vec++;
    if (y_a !== 10'd400) begin
      n_err++;
      $display("FAIL idle_y: got %0d expected 400", y_a);
    end
  endtask

  task automatic test_full_jump();
    press();
    for (int t = 1; t <= 31; t++) begin
      tick();
      if (t == 1) begin
        n_vec++;
        if (rise_a !== 1'b1 || y_a !== 10'd400) begin
          n_err++;
          $display("FAIL jump_t1: got rise=%0b y=%0d expected 1 400", rise_a, y_a);
        end
      end
      if (t == 2) begin
        n_vec++;
        if (y_a !== 10'd385) begin
          n_err++;
          $display("FAIL jump_t2_y: got %0d expected 385", y_a);
        end
      end
      if (t == 16) begin
        n_vec++;
        if (y_a !== 10'd280 || rise_a !== 1'b0 || air_a !== 1'b1) begin
          n_err++;
          $display("FAIL jump_apex: got y=%0d rise=%0b air=%0b expected 280 0 1", y_a, rise_a, air_a);
        end
      end
      if (t == 30) begin
        n_vec++;
        if (air_a !== 1'b1 || land_a !== 1'b0) begin
          n_err++;
          $display("FAIL jump_t30: got air=%0b land=%0b expected 1 0", air_a, land_a);
        end
      end
      if (t == 31) begin
        n_vec++;
        if (y_a !== 10'd400 || land_a !== 1'b1 || air_a !== 1'b0) begin
          n_err++;
          $display("FAIL jump_land: got y=%0d land=%0b air=%0b expected 400 1 0", y_a, land_a, air_a);
        end
      end
      idle(1);
    end
    n_vec++;
    if (land_a !== 1'b0) begin
      n_err++;
      $display("FAIL landed_width: got %0b expected 0", land_a);
    end
    settle();
  endtask

  task automatic test_ceiling();
    int miny, maxd, prev, k;
    bit clamp_rise;
    press();
    miny = 1023; maxd = 0; prev = 400; k = 0; clamp_rise = 0;
    tick();
    idle(1);
    while (air_b && k < 200) begin
      tick();
      n_vec++;
      if (y_b !== 10'(mb.y) || rise_b !== mb.up) begin
        n_err++;
        $display("FAIL ceiling_track: got y=%0d rise=%0b expected %0d %0b", y_b, rise_b, mb.y, mb.up);
      end
      if (int'(y_b) < miny) miny = int'(y_b);
      if (int'(y_b) - prev > maxd) maxd = int'(y_b) - prev;
      if (y_b == 10'd40 && rise_b) clamp_rise = 1;
      prev = int'(y_b);
      idle(1);
      k++;
    end
    n_vec++;
    if (miny != 40 || maxd != 15 || y_b !== 10'd400 || clamp_rise) begin
      n_err++;
      $display("FAIL ceiling: got min=%0d maxstep=%0d y=%0d riseat40=%0b expected 40 15 400 0", miny, maxd, y_b, clamp_rise);
    end
    settle();
  endtask

  task automatic test_midair();
    press();
    for (int t = 1; t <= 20; t++) begin
      tick();
      idle(1);
    end
    press();
    settle();
    for (int t = 0; t < 5; t++) begin
      tick();
      idle(1);
    end
    n_vec++;
    if (y_a !== 10'd400 || air_a !== 1'b0 || y_b !== 10'd400 || air_b !== 1'b0) begin
      n_err++;
      $display("FAIL midair_relaunch: got ya=%0d aira=%0b yb=%0d airb=%0b expected 400 0 400 0", y_a, air_a, y_b, air_b);
    end
  endtask

  task automatic test_held();
    int la, lb;
    la = 0; lb = 0;
    jump_btn = 1'b1;
    idle(4);
    for (int t = 0; t < 100; t++) begin
      tick();
      if (land_a === 1'b1) la++;
      if (land_b === 1'b1) lb++;
      idle(1);
    end
    n_vec++;
    if (la != 1 || lb != 1 || air_a !== 1'b0) begin
      n_err++;
      $display("FAIL held_one_jump: got jumps a=%0d b=%0d air=%0b expected 1 1 0", la, lb, air_a);
    end
    jump_btn = 1'b0;
    idle(4);
    press();
    for (int t = 1; t <= 31; t++) begin
      tick();
      if (t == 31) begin
        n_vec++;
        if (land_a !== 1'b1) begin
          n_err++;
          $display("FAIL held_second_jump: got land=%0b expected 1", land_a);
        end
      end
      idle(1);
    end
    settle();
  endtask

  task automatic test_reset_midjump();
    press();
    for (int t = 1; t <= 16; t++) begin
      tick();
      idle(1);
    end
    n_vec++;
    if (y_a !== 10'd280) begin
      n_err++;
      $display("FAIL rstmid_apex: got %0d expected 280", y_a);
    end
    rst = 1'b1;
    update = 1'b1;
    idle(1);
    rst = 1'b0;
    update = 1'b0;
    n_vec++;
    if (y_a !== 10'd400 || air_a !== 1'b0 || land_a !== 1'b0 || air_b !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid: got y=%0d air=%0b land=%0b airb=%0b expected 400 0 0 0", y_a, air_a, land_a, air_b);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_a, exp_b;
    for (int c = 0; c < 3000; c++) begin
      update = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) jump_btn = ~jump_btn;
      rst = ($urandom_range(0, 599) == 0);
      @(posedge clk);
      #1;
      exp_a = {10'(ma.y), ma.air, ma.up, ma.landed};
      exp_b = {10'(mb.y), mb.air, mb.up, mb.landed};
      n_vec++;
      if ({y_a, air_a, rise_a, land_a} !== exp_a) begin
        n_err++;
        $display("FAIL random_a cyc%0d: got y=%0d air=%0b rise=%0b land=%0b expected y=%0d air=%0b rise=%0b land=%0b",
                 c, y_a, air_a, rise_a, land_a, exp_a[12:3], exp_a[2], exp_a[1], exp_a[0]);
      end
      n_vec++;
      if ({y_b, air_b, rise_b, land_b} !== exp_b) begin
        n_err++;
        $display("FAIL random_b cyc%0d: got y=%0d air=%0b rise=%0b land=%0b expected y=%0d air=%0b rise=%0b land=%0b",
                 c, y_b, air_b, rise_b, land_b, exp_b[12:3], exp_b[2], exp_b[1], exp_b[0]);
      end
    end
    rst = 1'b0;
    update = 1'b0;
    jump_btn = 1'b0;
  endtask

  initial begin
    idle(1);
    test_reset();
    test_full_jump();
    test_ceiling();
    test_midair();
    test_held();
    test_reset_midjump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dragon_jump.md
# dragon_jump

Vertical-motion controller for the dragon sprite. It consumes the one-cycle game-tick pulse `update` from the tick generator, which fires once every 1,777,778 `pixel_clk` cycles. On a debounced jump request it runs a RISE/FALL trajectory under constant gravity. It publishes the sprite's top-edge Y coordinate to the VGA renderer and collision logic.

## Interface
- `GROUND_Y`, 400: resting Y coordinate in pixels; Y grows downward; must be < 1024.
- `TOP_Y`, 40: ceiling; Y is never driven below this value; must be < `GROUND_Y`.
- `JUMP_V0`, 15: initial upward speed, in pixels/tick; range 1–63.
- `GRAVITY`, 1: speed change per tick, in pixels/tick; range 1–63.
- `MAX_FALL`, 15: terminal downward speed, in pixels/tick; range 1–63.
- `pixel_clk`  in  1  the only clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `update`  in  1  game-tick strobe, one cycle wide, synchronous to `pixel_clk`.
- `jump_btn`  in  1  raw push-button input, asynchronous, active-high.
- `dragon_y`  out  10  registered sprite Y coordinate.
- `airborne`  out  1  high while the state is RISE or FALL.
- `rising`  out  1  high while the state is RISE; the renderer uses it for sprite frame select.
- `landed`  out  1  one-cycle pulse on the return to GROUND.

## Operation
- Button input path:
  - `jump_btn` passes through a 2-flop synchronizer.
  - A rising-edge detector follows, producing `jump_edge`.
  - `jump_edge` sets `jump_pending`.
- `jump_pending` rules:
  - Cleared when consumed.
  - Cleared on any tick while airborne. Presses made in the air are discarded, not buffered.
- State machine:
  - States are GROUND, RISE and FALL.
  - Speed `vel` is a 6-bit unsigned magnitude; the state supplies the direction.
  - All transitions happen only on cycles with `update`=1. Between ticks all state is held.
- GROUND:
  - Trigger: a tick arrives while (`jump_pending` | `jump_edge`) is set.
  - Action: go to RISE, load `vel`=`JUMP_V0`, clear `jump_pending`.
  - `dragon_y` does not move on this tick.
- RISE, on each tick:
  - Compute `y_n` = `dragon_y` − `vel` at 11-bit signed width.
  - If `y_n` < `TOP_Y`: set `dragon_y`=`TOP_Y`, `vel`=0, go to FALL (ceiling clamp).
  - Else: set `dragon_y`=`y_n`.
  - Then, if `vel` ≤ `GRAVITY`: set `vel`=0 and go to FALL (apex). Otherwise set `vel`=`vel`−`GRAVITY`.
- FALL, on each tick:
  - Compute `v_n` = min(`vel`+`GRAVITY`, `MAX_FALL`), evaluated at 7 bits with no wrap.
  - Compute `y_n` = `dragon_y` + `v_n` at 11 bits.
  - If `y_n` ≥ `GROUND_Y`: set `dragon_y`=`GROUND_Y`, `vel`=0, go to GROUND, pulse `landed`.
  - Else: set `dragon_y`=`y_n` and `vel`=`v_n`.
- With default parameters:
  - Apex Y=280 after 15 RISE ticks.
  - Landing exactly on Y=400 after 15 FALL ticks.
  - 31 ticks from the launch tick to landing.
- `rst` has priority over everything, `update` included. Reset mid-jump snaps the sprite to the ground immediately.

## Timing
- Reset values:
  - `dragon_y`=`GROUND_Y`, state GROUND, `vel`=0.
  - `airborne`=0, `rising`=0, `landed`=0.
  - `jump_pending`=0; synchronizer and edge flops 0.
- All outputs are registered. Every change appears the cycle after the edge on which `update`=1 was sampled.
- `landed` is high for exactly one `pixel_clk` cycle, the cycle after the landing tick.
- Button latency: 2 cycles of synchronizer plus 1 cycle of edge detect. An edge is usable by a tick at the earliest 3 cycles after the button rises.
- A button held high produces only one jump. The button must go low and high again before a new edge is seen.
- An edge that coincides with a tick in GROUND launches on that tick.
- An edge that coincides with the landing tick is discarded, because that tick is still airborne.
- `update` held high for several cycles (a protocol violation): each high cycle counts as a tick. No protection is required.

## Test plan
- Reset then idle: assert `rst` for 2 cycles, then issue 10 ticks -> `dragon_y`=400, `airborne`=0, `landed` never asserts.
- Full default jump: pulse `jump_btn`, then issue ticks:
  - After tick 1: `rising`=1, `dragon_y`=400.
  - After tick 2: `dragon_y`=385.
  - After tick 16: `dragon_y`=280, `rising`=0.
  - After tick 31: `dragon_y`=400, `landed` is a 1-cycle pulse, `airborne`=0.
- Ceiling clamp with `JUMP_V0`=40 (other parameters default): jump -> `dragon_y` is clamped to 40, FALL follows on the next tick, terminal speed stays at 15, and the sprite lands at exactly 400.
- Mid-air press: press `jump_btn` during FALL -> no relaunch after landing. A further 5 ticks leave `dragon_y`=400.
- Held button: hold `jump_btn` high across 100 ticks -> exactly one jump. Release and press again -> a second jump.
- Reset mid-jump: assert `rst` at apex with `dragon_y`=280 -> next cycle `dragon_y`=400, `airborne`=0, `landed`=0.
